// File: rtl/compression_pkg.sv
// Shared types, field positions and word-format helpers for the compressed block packer.
package compression_pkg;

    localparam int unsigned OUT_WIDTH = 32;

    localparam int unsigned HDR_DC_LSB   = 0;
    localparam int unsigned HDR_MASK_LSB = 16;
    localparam int unsigned HDR_CNT_LSB  = 20;
    localparam int unsigned HDR_SEQ_LSB  = 24;

    localparam int unsigned CW_COEF_LSB  = 0;
    localparam int unsigned CW_IDX_LSB   = 16;
    localparam int unsigned CW_SLOT_LSB  = 24;

    // Fields are stored already extended to their on-wire widths.
    typedef struct packed {
        logic [15:0]      dc;
        logic [3:0][15:0] coef;
        logic [3:0][7:0]  index;
        logic [3:0]       mask;
        logic [2:0]       cnt;
        logic [7:0]       seq;
    } blk_rec_t;

    typedef enum logic [1:0] { IDLE, HEADER, COEF } pack_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

    function automatic logic any_set(input logic [3:0] mask, input int unsigned from);
        any_set = 1'b0;
        for (int unsigned k = 0; k < 4; k++)
            if (k >= from && mask[k]) any_set = 1'b1;
    endfunction

    // Lowest set mask bit at or above 'from'; meaningful only when any_set() is true.
    function automatic logic [1:0] first_set(input logic [3:0] mask, input int unsigned from);
        first_set = 2'd0;
        for (int unsigned k = 4; k > 0; k--)
            if (k - 1 >= from && mask[k - 1]) first_set = 2'(k - 1);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] header_word(input blk_rec_t r);
        header_word = '0;
        header_word[HDR_DC_LSB +: 16]  = r.dc;
        header_word[HDR_MASK_LSB +: 4] = r.mask;
        header_word[HDR_CNT_LSB +: 3]  = r.cnt;
        header_word[HDR_SEQ_LSB +: 8]  = r.seq;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] coef_word(input blk_rec_t r, input logic [1:0] k);
        coef_word = '0;
        coef_word[CW_COEF_LSB +: 16] = r.coef[k];
        coef_word[CW_IDX_LSB +: 8]   = r.index[k];
        coef_word[CW_SLOT_LSB +: 2]  = k;
    endfunction

endpackage

// File: rtl/compressed_rec_fifo.sv
// Two-entry block record FIFO; exposes both entries so the packer can chain records without a bubble.
module compressed_rec_fifo
    import compression_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  logic     pop_i,
    input  blk_rec_t wr_data_i,
    output blk_rec_t head_o,
    output blk_rec_t next_o,
    output logic [1:0] count_o,
    output logic     accept_o,
    output logic     drop_o
);

    blk_rec_t   mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q;
    logic       pop_ok;

    assign pop_ok   = pop_i && (count_q != 2'd0);
    // A full buffer still takes a record when the head leaves on the same edge.
    assign accept_o = push_i && ((count_q != 2'd2) || pop_ok);
    assign drop_o   = push_i && !accept_o;
    assign head_o   = mem_q[rd_ptr_q];
    assign next_o   = mem_q[~rd_ptr_q];
    assign count_o  = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (accept_o) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)   rd_ptr_q <= ~rd_ptr_q;
            if (accept_o && !pop_ok)      count_q <= count_q + 2'd1;
            else if (!accept_o && pop_ok) count_q <= count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_o) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/compressed_block_packer.sv
// Captures thresholded 8x8 block results and serialises each into a header plus non-zero coefficient words.
module compressed_block_packer
    import compression_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [WIDTH-1:0]       in_dc,
    input  logic signed [WIDTH-1:0]       in_coef [4],
    input  logic [INDEX_WIDTH-1:0]        in_index [4],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_last,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          busy
);

    blk_rec_t       rec_in, cur, nxt, load_rec;
    logic [1:0]     count;
    logic           accept, drop, pop, fire, finish, load_en;
    logic           nx_found, last_after;
    logic [1:0]     nx_slot;
    int unsigned    scan_from;

    pack_state_e    state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [7:0]     seq_q;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic           overflow_q;

    always_comb begin
        rec_in    = '0;
        rec_in.dc = 16'(in_dc);
        for (int unsigned k = 0; k < 4; k++) begin
            rec_in.coef[k]  = 16'(in_coef[k]);
            rec_in.index[k] = 8'(in_index[k]);
            rec_in.mask[k]  = (in_coef[k] != '0);
        end
        rec_in.cnt = popcount4(rec_in.mask);
        rec_in.seq = seq_q;
    end

    compressed_rec_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (in_valid),
        .pop_i     (pop),
        .wr_data_i (rec_in),
        .head_o    (cur),
        .next_o    (nxt),
        .count_o   (count),
        .accept_o  (accept),
        .drop_o    (drop)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pop         = 1'b0;
        finish      = 1'b0;
        load_en     = 1'b0;
        load_rec    = cur;

        fire       = out_valid_q && out_ready;
        scan_from  = (state_q == COEF) ? 32'(slot_q) + 32'd1 : 32'd0;
        nx_found   = any_set(cur.mask, scan_from);
        nx_slot    = first_set(cur.mask, scan_from);
        last_after = !any_set(cur.mask, 32'(nx_slot) + 32'd1);

        case (state_q)
            // An empty buffer forwards the arriving record straight to the output register.
            IDLE: begin
                if (count != 2'd0) begin
                    load_en  = 1'b1;
                    load_rec = cur;
                end else if (in_valid) begin
                    load_en  = 1'b1;
                    load_rec = rec_in;
                end
            end
            HEADER, COEF: begin
                if (fire) begin
                    if (nx_found) begin
                        state_d    = COEF;
                        slot_d     = nx_slot;
                        out_data_d = coef_word(cur, nx_slot);
                        out_last_d = last_after;
                    end else begin
                        pop    = 1'b1;
                        finish = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Successor is the second buffered entry, or a record arriving on the pop edge.
        if (finish) begin
            if (count == 2'd2 || in_valid) begin
                load_en  = 1'b1;
                load_rec = (count == 2'd2) ? nxt : rec_in;
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end

        if (load_en) begin
            state_d     = HEADER;
            out_valid_d = 1'b1;
            out_data_d  = header_word(load_rec);
            out_last_d  = (load_rec.cnt == 3'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_q      <= 2'd0;
            seq_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            if (accept) seq_q <= seq_q + 8'd1;
            if (drop)              overflow_q <= 1'b1;
            else if (overflow_clr) overflow_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign busy      = (count != 2'd0);

endmodule

// File: tb/tb_compressed_block_packer.sv
// Self-checking bench for compressed_block_packer: directed scenarios plus a randomized run against a word-queue model.
module tb_compressed_block_packer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               overflow_clr = 1'b0;
    logic signed [15:0] in_dc = '0;
    logic signed [15:0] in_coef [4];
    logic [5:0]         in_index [4];
    logic               out_valid, out_last, overflow, busy;
    logic [31:0]        out_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t      exp_q [$];
    logic [7:0] m_seq;
    logic       m_ovf;

    compressed_block_packer #(.WIDTH(16), .INDEX_WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_dc        (in_dc),
        .in_coef      (in_coef),
        .in_index     (in_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // coefs = {c3,c2,c1,c0}, idxs = {i3,i2,i1,i0}
    task automatic set_rec(input logic [15:0] dc, input logic [63:0] coefs, input logic [31:0] idxs);
        in_dc = dc;
        for (int k = 0; k < 4; k++) begin
            in_coef[k]  = coefs[16*k +: 16];
            in_index[k] = 6'(idxs[8*k +: 8]);
        end
    endtask

    // Reference: the output is a queue of words; a block is buffered until its last word is taken.
    task automatic model_edge();
        int         occ;
        int         cnt;
        int         sent;
        logic       pop_now;
        logic       dropped;
        logic [3:0] mask;
        word_t      w;
        occ = 0;
        foreach (exp_q[i]) if (exp_q[i].l) occ++;
        pop_now = (exp_q.size() > 0) && out_ready && exp_q[0].l;
        dropped = in_valid && (occ >= 2) && !pop_now;
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && !dropped) begin
            cnt = 0;
            for (int k = 0; k < 4; k++) begin
                mask[k] = (in_coef[k] != 0);
                if (mask[k]) cnt++;
            end
            w.d = {m_seq, 1'b0, 3'(cnt), mask, in_dc};
            w.l = (cnt == 0);
            exp_q.push_back(w);
            sent = 0;
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    sent++;
                    w.d = {6'b0, 2'(k), 8'(in_index[k]), in_coef[k]};
                    w.l = (sent == cnt);
                    exp_q.push_back(w);
                end
            end
            m_seq = m_seq + 8'd1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        overflow_clr = 1'b0;
        exp_q.delete();
        m_seq = 8'd0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_last, overflow, busy, out_data} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b l=%b ovf=%b busy=%b d=%h, want all zero",
                     out_valid, out_last, overflow, busy, out_data);
        end
        apply_reset();
    endtask

    task automatic test_single_block();
        logic [33:0] want [4];
        want[0] = {1'b1, 1'b0, 32'h0025_0123};
        want[1] = {1'b1, 1'b0, 32'h0001_0005};
        want[2] = {1'b1, 1'b1, 32'h0209_FFFD};
        want[3] = {1'b0, 1'b0, 32'h0209_FFFD};
        apply_reset();
        out_ready = 1'b1;
        set_rec(16'h0123, {16'h0000, 16'hFFFD, 16'h0000, 16'h0005}, {8'd10, 8'd9, 8'd2, 8'd1});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({out_valid, out_last, out_data} !== want[i]) begin
                miscompares++;
                $display("FAIL single_word%0d: got v=%b l=%b d=%h, want %h", i, out_valid, out_last, out_data, want[i]);
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_zero_coef();
        apply_reset();
        out_ready = 1'b1;
        set_rec(16'hFFFF, 64'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_last, out_data} !== {2'b11, 32'h0000_FFFF}) begin
            miscompares++;
            $display("FAIL zero_hdr: got v=%b l=%b d=%h, want v=1 l=1 d=0000ffff", out_valid, out_last, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_idle: got out_valid=%b want 0", out_valid);
        end
        set_rec(16'h0002, {16'h0007, 48'd0}, {8'd3, 24'd0});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_last, out_data} !== {2'b10, 32'h0118_0002}) begin
            miscompares++;
            $display("FAIL zero_next_seq: got v=%b l=%b d=%h, want v=1 l=0 d=01180002", out_valid, out_last, out_data);
        end
        tick();
        vectors++;
        if ({out_valid, out_last, out_data} !== {2'b11, 32'h0303_0007}) begin
            miscompares++;
            $display("FAIL zero_next_coef: got v=%b l=%b d=%h, want v=1 l=1 d=03030007", out_valid, out_last, out_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic pat [4];
        int   dut_words;
        int   dut_lasts;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        dut_words = 0;
        dut_lasts = 0;
        apply_reset();
        set_rec(16'h1000, {16'd4, 16'd3, 16'd2, 16'd1}, {8'd40, 8'd30, 8'd20, 8'd10});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            out_ready = pat[i % 4];
            vectors++;
            if (out_valid !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("FAIL bp_valid cycle %0d: got %b want %b", i, out_valid, exp_q.size() != 0);
            end else if (out_valid) begin
                vectors++;
                if ({out_last, out_data} !== {exp_q[0].l, exp_q[0].d}) begin
                    miscompares++;
                    $display("FAIL bp_word cycle %0d: got l=%b d=%h want l=%b d=%h",
                             i, out_last, out_data, exp_q[0].l, exp_q[0].d);
                end
                if (out_ready) begin
                    dut_words++;
                    if (out_last) dut_lasts++;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (dut_words !== 5 || dut_lasts !== 1) begin
            miscompares++;
            $display("FAIL bp_count: got words=%0d lasts=%0d want words=5 lasts=1", dut_words, dut_lasts);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            set_rec(16'(8'h11 * (p + 1)), 64'd0, 32'd0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (7) tick();
        end
        vectors++;
        if ({overflow, busy, out_valid, out_last, out_data} !== {4'b1111, 32'h0000_0011}) begin
            miscompares++;
            $display("FAIL ovf_state: got ovf=%b busy=%b v=%b l=%b d=%h want 1 1 1 1 00000011",
                     overflow, busy, out_valid, out_last, out_data);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_data} !== {1'b1, 32'h0100_0022}) begin
            miscompares++;
            $display("FAIL ovf_second: got v=%b d=%h want v=1 d=01000022", out_valid, out_data);
        end
        tick();
        vectors++;
        if ({out_valid, busy, overflow} !== 3'b001) begin
            miscompares++;
            $display("FAIL ovf_drained: got v=%b busy=%b ovf=%b want 0 0 1", out_valid, busy, overflow);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_seq_wrap();
        logic [7:0] want_seq;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            want_seq = 8'(i);
            set_rec(16'(i), 64'd0, 32'd0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || out_data[31:24] !== want_seq) begin
                miscompares++;
                $display("FAIL seq_wrap blk %0d: got v=%b seq=%0d want v=1 seq=%0d", i, out_valid, out_data[31:24], want_seq);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_coef();
        apply_reset();
        out_ready = 1'b1;
        set_rec(16'h0F0F, {16'd9, 16'd8, 16'd7, 16'd6}, {8'd4, 8'd3, 8'd2, 8'd1});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, busy, out_data} !== 34'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got v=%b busy=%b d=%h want all zero", out_valid, busy, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_seq = 8'd0;
        m_ovf = 1'b0;
        set_rec(16'h0005, 64'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_last, out_data} !== {2'b11, 32'h0000_0005}) begin
            miscompares++;
            $display("FAIL midreset_restart: got v=%b l=%b d=%h want v=1 l=1 d=00000005", out_valid, out_last, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        int occ;
        logic [63:0] coefs;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            occ = 0;
            foreach (exp_q[j]) if (exp_q[j].l) occ++;
            vectors++;
            if (out_valid !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("FAIL rand_valid cycle %0d: got %b want %b", i, out_valid, exp_q.size() != 0);
            end else if (out_valid) begin
                vectors++;
                if ({out_last, out_data} !== {exp_q[0].l, exp_q[0].d}) begin
                    miscompares++;
                    $display("FAIL rand_word cycle %0d: got l=%b d=%h want l=%b d=%h",
                             i, out_last, out_data, exp_q[0].l, exp_q[0].d);
                end
            end
            vectors++;
            if (busy !== (occ != 0) || overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL rand_status cycle %0d: got busy=%b ovf=%b want busy=%b ovf=%b",
                         i, busy, overflow, occ != 0, m_ovf);
            end
            for (int k = 0; k < 4; k++)
                coefs[16*k +: 16] = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
            set_rec(16'($urandom), coefs, $urandom);
            out_ready    = ($urandom_range(0, 3) != 0);
            in_valid     = ($urandom_range(0, 4) == 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0;
        overflow_clr = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_coef[k]  = '0;
            in_index[k] = '0;
        end
        m_seq = 8'd0;
        m_ovf = 1'b0;
        test_reset();
        test_single_block();
        test_zero_coef();
        test_backpressure();
        test_overflow();
        test_seq_wrap();
        test_reset_mid_coef();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
